// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: stall, flush and forwarding selects.
// Optional PERF_CNT_EN adds stall_cycles / flush_events counters.
//
// state    | meaning
// RUN      | normal issue; load-use bubbles and branch flush start here
// MEM_WAIT | data memory busy, whole pipe frozen
// FLUSH    | injecting bubbles into IF/ID after a taken branch
module pipeline_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_dst,
  input  logic        ex_wr,
  input  logic        ex_load,
  input  logic        ex_br_taken,
  input  logic [4:0]  mem_dst,
  input  logic        mem_wr,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        stall_if,
  output logic        stall_id,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        stall_all,
  output logic [1:0]  fwd_rs1,
  output logic [1:0]  fwd_rs2,
  output logic        err_timeout,
  output logic [1:0]  state
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_FLUSH    = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] FLUSH_FULL = 3'(FLUSH_CYCLES);
  localparam logic [8:0] TIMEOUT9   = 9'(MEM_TIMEOUT);
  localparam logic [7:0] TIMEOUT8   = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       pending_q, pending_d;
  logic [4:0] wb_dst_q;
  logic       wb_wr_q;

  logic       stall_c, freeze_c, flush_id_c, flush_ex_c, err_c;
  logic       load_use, mem_miss;
  logic [8:0] wait_idx;
  logic [7:0] wait_sat;
  logic [1:0] fwd1_c, fwd2_c;

  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] md, input logic mw,
                                         input logic [4:0] wd, input logic ww);
    if (mw && reg_match(md, rs))
      return 2'd1;
    else if (ww && reg_match(wd, rs))
      return 2'd2;
    return 2'd0;
  endfunction

  assign load_use = id_valid & ex_load & ex_wr &
                    ((id_use_rs1 & reg_match(ex_dst, id_rs1)) |
                     (id_use_rs2 & reg_match(ex_dst, id_rs2)));
  assign mem_miss = mem_req & ~mem_ready;

  // Index of the current not-ready wait cycle; the cycle that enters MEM_WAIT is number 1.
  assign wait_idx = (state_q == S_MEM_WAIT) ? ({1'b0, wait_cnt_q} + 9'd1) : 9'd1;
  assign wait_sat = (wait_idx >= TIMEOUT9) ? TIMEOUT8 : wait_idx[7:0];

  assign fwd1_c = fwd_sel(id_rs1, mem_dst, mem_wr, wb_dst_q, wb_wr_q);
  assign fwd2_c = fwd_sel(id_rs2, mem_dst, mem_wr, wb_dst_q, wb_wr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      flush_cnt_q <= 3'd0;
      wait_cnt_q  <= 8'd0;
      pending_q   <= 1'b0;
      wb_dst_q    <= 5'd0;
      wb_wr_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      pending_q   <= pending_d;
      if (!freeze_c) begin
        wb_dst_q <= mem_dst;
        wb_wr_q  <= mem_wr;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    pending_d   = pending_q;
    stall_c     = 1'b0;
    freeze_c    = 1'b0;
    flush_id_c  = 1'b0;
    flush_ex_c  = 1'b0;
    err_c       = 1'b0;
    case (state_q)
      S_RUN: begin
        if (mem_miss) begin
          stall_c    = 1'b1;
          freeze_c   = 1'b1;
          err_c      = (wait_idx == TIMEOUT9);
          wait_cnt_d = wait_sat;
          pending_d  = ex_br_taken;
          state_d    = S_MEM_WAIT;
        end else if (ex_br_taken) begin
          flush_id_c = 1'b1;
          flush_ex_c = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            flush_cnt_d = FLUSH_LOAD;
            state_d     = S_FLUSH;
          end
        end else if (load_use) begin
          stall_c    = 1'b1;
          flush_ex_c = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        stall_c  = 1'b1;
        freeze_c = 1'b1;
        if (mem_ready) begin
          pending_d  = 1'b0;
          wait_cnt_d = 8'd0;
          // An interrupted flush resumes with its saved count; otherwise a latched branch starts a full one.
          if (flush_cnt_q != 3'd0) begin
            state_d = S_FLUSH;
          end else if (pending_q || ex_br_taken) begin
            flush_cnt_d = FLUSH_FULL;
            state_d     = S_FLUSH;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          pending_d  = pending_q | ex_br_taken;
          err_c      = (wait_idx == TIMEOUT9);
          wait_cnt_d = wait_sat;
        end
      end
      S_FLUSH: begin
        if (mem_miss) begin
          stall_c    = 1'b1;
          freeze_c   = 1'b1;
          err_c      = (wait_idx == TIMEOUT9);
          wait_cnt_d = wait_sat;
          pending_d  = 1'b0;
          state_d    = S_MEM_WAIT;
        end else begin
          flush_id_c  = 1'b1;
          flush_cnt_d = flush_cnt_q - 3'd1;
          if (flush_cnt_q <= 3'd1)
            state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  assign stall_if    = ~rst & stall_c;
  assign stall_id    = ~rst & stall_c;
  assign stall_all   = ~rst & freeze_c;
  assign flush_id    = ~rst & flush_id_c;
  assign flush_ex    = ~rst & flush_ex_c;
  assign err_timeout = ~rst & err_c;
  assign fwd_rs1     = rst ? 2'd0 : fwd1_c;
  assign fwd_rs2     = rst ? 2'd0 : fwd2_c;
  assign state       = rst ? 2'd0 : state_q;

`ifdef PERF_CNT_EN
  logic flush_ev;

  assign flush_ev = ((state_q == S_RUN) & ~mem_miss & ex_br_taken) |
                    ((state_q == S_MEM_WAIT) & mem_ready & (flush_cnt_q == 3'd0) &
                     (pending_q | ex_br_taken));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 32'd0;
      flush_events <= 32'd0;
    end else begin
      if (stall_c)
        stall_cycles <= stall_cycles + 32'd1;
      if (flush_ev)
        flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, hand-written episode sequences and
// randomized traffic against a cycle-level reference model.
module tb_pipeline_ctrl;

  localparam int FLUSH_CYCLES = 2;
  localparam int MEM_TIMEOUT  = 3;

  logic       clk, rst;
  logic       id_valid, id_use_rs1, id_use_rs2;
  logic [4:0] id_rs1, id_rs2, ex_dst, mem_dst;
  logic       ex_wr, ex_load, ex_br_taken, mem_wr, mem_req, mem_ready;
  logic       stall_if, stall_id, flush_id, flush_ex, stall_all, err_timeout;
  logic [1:0] fwd_rs1, fwd_rs2, state;
  logic [11:0] outv;

  int checks = 0;
  int errors = 0;

  pipeline_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_dst(ex_dst), .ex_wr(ex_wr), .ex_load(ex_load), .ex_br_taken(ex_br_taken),
    .mem_dst(mem_dst), .mem_wr(mem_wr), .mem_req(mem_req), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id), .flush_ex(flush_ex),
    .stall_all(stall_all), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .err_timeout(err_timeout), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle: {stall_if, stall_id, flush_id, flush_ex, stall_all, fwd_rs1, fwd_rs2, err_timeout, state}
  assign outv = {stall_if, stall_id, flush_id, flush_ex, stall_all, fwd_rs1, fwd_rs2, err_timeout, state};

  function automatic logic [11:0] mk(input bit sif, input bit sid, input bit fid, input bit fex,
                                     input bit sall, input logic [1:0] f1, input logic [1:0] f2,
                                     input bit err, input logic [1:0] st);
    return {sif, sid, fid, fex, sall, f1, f2, err, st};
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (sif sid fid fex sall f1 f2 err st)", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_dst = 0; ex_wr = 0; ex_load = 0; ex_br_taken = 0;
    mem_dst = 0; mem_wr = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_at_negedge(input string name, input logic [11:0] exp);
    @(negedge clk);
    chk(name, outv, exp);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] exd;
    logic       exw, exl;
    logic [4:0] md;
    logic       mw;
    logic [11:0] exp;
  } vec_t;

  vec_t tab[14];

  // Reference model state
  int         m_mode;     // 0 run, 1 memory wait, 2 flush
  int         m_left;     // flush bubbles still owed
  int         m_waited;   // not-ready cycles in the current wait episode
  bit         m_pend;
  logic [4:0] m_wb_dst;
  bit         m_wb_wr;

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (rs != 0 && mem_wr && mem_dst == rs) return 2'd1;
    if (rs != 0 && m_wb_wr && m_wb_dst == rs) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_cycle(output logic [11:0] e);
    bit sif, fid, fex, sall, err, lu;
    logic [1:0] st, f1, f2;
    sif = 0; fid = 0; fex = 0; sall = 0; err = 0;
    st = 2'(m_mode);
    f1 = ref_fwd(id_rs1);
    f2 = ref_fwd(id_rs2);
    lu = id_valid && ex_load && ex_wr && ex_dst != 0 &&
         ((id_use_rs1 && ex_dst == id_rs1) || (id_use_rs2 && ex_dst == id_rs2));
    if (m_mode == 1 || (mem_req && !mem_ready)) begin
      sif = 1; sall = 1;
      if (m_mode != 1) begin
        m_mode = 1; m_waited = 0; m_pend = 0;
      end
      m_pend = m_pend | ex_br_taken;
      if (mem_ready) begin
        if (m_left > 0) m_mode = 2;
        else if (m_pend) begin m_mode = 2; m_left = FLUSH_CYCLES; end
        else m_mode = 0;
        m_pend = 0;
      end else begin
        m_waited++;
        err = (m_waited == MEM_TIMEOUT);
      end
    end else if (m_mode == 2) begin
      fid = 1;
      m_left--;
      if (m_left == 0) m_mode = 0;
    end else if (ex_br_taken) begin
      fid = 1; fex = 1;
      m_left = FLUSH_CYCLES - 1;
      if (m_left > 0) m_mode = 2;
    end else if (lu) begin
      sif = 1; fex = 1;
    end
    if (!sall) begin
      m_wb_dst = mem_dst;
      m_wb_wr  = mem_wr;
    end
    e = mk(sif, sif, fid, fex, sall, f1, f2, err, st);
  endtask

  initial begin
    logic [11:0] e;
    logic [11:0] seq_d[8];
    clear_inputs();

    tab[0]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, mk(0,0,0,0,0,0,0,0,0)};
    tab[1]  = '{1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, mk(1,1,0,1,0,0,0,0,0)};
    tab[2]  = '{1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, mk(1,1,0,1,0,0,0,0,0)};
    tab[3]  = '{1'b1, 5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, mk(0,0,0,0,0,0,0,0,0)};
    tab[4]  = '{1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, mk(0,0,0,0,0,0,0,0,0)};
    tab[5]  = '{1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, mk(0,0,0,0,0,0,0,0,0)};
    tab[6]  = '{1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, mk(0,0,0,0,0,0,0,0,0)};
    tab[7]  = '{1'b1, 5'd5, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, mk(0,0,0,0,0,1,0,0,0)};
    tab[8]  = '{1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, mk(0,0,0,0,0,2,2,0,0)};
    tab[9]  = '{1'b1, 5'd9, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, mk(0,0,0,0,0,1,0,0,0)};
    tab[10] = '{1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b0, mk(0,0,0,0,0,2,0,0,0)};
    tab[11] = '{1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b0, mk(0,0,0,0,0,0,0,0,0)};
    tab[12] = '{1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, mk(0,0,0,0,0,0,0,0,0)};
    tab[13] = '{1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, mk(1,1,0,1,0,1,0,0,0)};

    // Reset holds every output low even with hazards on the inputs.
    rst = 1'b1;
    mem_req = 1; ex_br_taken = 1; mem_wr = 1; mem_dst = 5'd5; id_rs1 = 5'd5;
    id_valid = 1; id_use_rs1 = 1; ex_load = 1; ex_wr = 1; ex_dst = 5'd5;
    #3 chk("reset_outputs", outv, 12'd0);
    do_reset();
    check_at_negedge("after_reset", 12'd0);
    next_cycle();

    // Vector table: RUN-state hazards and forwarding.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      id_valid = tab[i].v; id_rs1 = tab[i].rs1; id_rs2 = tab[i].rs2;
      id_use_rs1 = tab[i].u1; id_use_rs2 = tab[i].u2;
      ex_dst = tab[i].exd; ex_wr = tab[i].exw; ex_load = tab[i].exl;
      mem_dst = tab[i].md; mem_wr = tab[i].mw;
      check_at_negedge($sformatf("vec%0d", i), tab[i].exp);
      next_cycle();
    end

    // Load-use bubble then MEM forwarding next cycle.
    do_reset();
    id_valid = 1; id_rs1 = 5'd5; id_use_rs1 = 1; ex_dst = 5'd5; ex_wr = 1; ex_load = 1;
    check_at_negedge("lu_stall", mk(1,1,0,1,0,0,0,0,0));
    next_cycle();
    ex_load = 0; ex_wr = 0; ex_dst = 0; mem_dst = 5'd5; mem_wr = 1;
    check_at_negedge("lu_fwd", mk(0,0,0,0,0,1,0,0,0));
    next_cycle();

    // Taken branch; a second branch during FLUSH is ignored.
    do_reset();
    ex_br_taken = 1;
    check_at_negedge("br_n", mk(0,0,1,1,0,0,0,0,0));
    next_cycle();
    check_at_negedge("br_n1", mk(0,0,1,0,0,0,0,0,2));
    next_cycle();
    ex_br_taken = 0;
    check_at_negedge("br_n2", mk(0,0,0,0,0,0,0,0,0));
    next_cycle();

    // Memory wait with a held branch: 4 not-ready cycles, ready cycle, then a full flush.
    do_reset();
    seq_d[0] = mk(1,1,0,0,1,0,0,0,0);
    seq_d[1] = mk(1,1,0,0,1,0,0,0,1);
    seq_d[2] = mk(1,1,0,0,1,0,0,1,1);
    seq_d[3] = mk(1,1,0,0,1,0,0,0,1);
    seq_d[4] = mk(1,1,0,0,1,0,0,0,1);
    seq_d[5] = mk(0,0,1,0,0,0,0,0,2);
    seq_d[6] = mk(0,0,1,0,0,0,0,0,2);
    seq_d[7] = mk(0,0,0,0,0,0,0,0,0);
    for (int c = 0; c < 8; c++) begin
      mem_req = (c < 5); mem_ready = (c == 4); ex_br_taken = (c < 5);
      check_at_negedge($sformatf("memwait_br_c%0d", c), seq_d[c]);
      next_cycle();
    end

    // Timeout: single pulse on the third wait cycle, stall continues.
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      mem_req = (c <= 7); mem_ready = (c == 7);
      if (c <= 6)
        e = mk(1,1,0,0,1,0,0,(c == 3),(c == 1) ? 2'd0 : 2'd1);
      else if (c == 7)
        e = mk(1,1,0,0,1,0,0,0,1);
      else
        e = 12'd0;
      check_at_negedge($sformatf("timeout_c%0d", c), e);
      next_cycle();
    end

    // Memory wait during FLUSH resumes the remaining bubble afterwards.
    do_reset();
    ex_br_taken = 1;
    check_at_negedge("resume_c1", mk(0,0,1,1,0,0,0,0,0));
    next_cycle();
    ex_br_taken = 0; mem_req = 1; mem_ready = 0;
    check_at_negedge("resume_c2", mk(1,1,0,0,1,0,0,0,2));
    next_cycle();
    mem_ready = 1;
    check_at_negedge("resume_c3", mk(1,1,0,0,1,0,0,0,1));
    next_cycle();
    mem_req = 0; mem_ready = 0;
    check_at_negedge("resume_c4", mk(0,0,1,0,0,0,0,0,2));
    next_cycle();
    check_at_negedge("resume_c5", 12'd0);
    next_cycle();

    // Async reset mid-FLUSH.
    do_reset();
    ex_br_taken = 1;
    next_cycle();
    ex_br_taken = 0; mem_wr = 1; mem_dst = 5'd3; id_rs1 = 5'd3;
    check_at_negedge("rstflush_pre", mk(0,0,1,0,0,1,0,0,2));
    #2 rst = 1'b1;
    #1 chk("rstflush_now", outv, 12'd0);
    clear_inputs();
    next_cycle();
    rst = 1'b0;
    check_at_negedge("rstflush_rel1", 12'd0);
    next_cycle();
    check_at_negedge("rstflush_rel2", 12'd0);
    next_cycle();

    // Async reset mid-MEM_WAIT.
    mem_req = 1; mem_ready = 0; ex_br_taken = 1;
    next_cycle();
    check_at_negedge("rstwait_pre", mk(1,1,0,0,1,0,0,0,1));
    #2 rst = 1'b1;
    #1 chk("rstwait_now", outv, 12'd0);
    clear_inputs();
    next_cycle();
    rst = 1'b0;
    check_at_negedge("rstwait_rel1", 12'd0);
    next_cycle();
    check_at_negedge("rstwait_rel2", 12'd0);
    next_cycle();

    // Randomized traffic against the reference model.
    do_reset();
    m_mode = 0; m_left = 0; m_waited = 0; m_pend = 0; m_wb_dst = 0; m_wb_wr = 0;
    for (int n = 0; n < 3000; n++) begin
      id_valid    = ($urandom_range(0, 3) != 0);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_use_rs1  = 1'($urandom_range(0, 1));
      id_use_rs2  = 1'($urandom_range(0, 1));
      ex_dst      = 5'($urandom_range(0, 3));
      ex_wr       = 1'($urandom_range(0, 1));
      ex_load     = 1'($urandom_range(0, 1));
      ex_br_taken = ($urandom_range(0, 6) == 0);
      mem_dst     = 5'($urandom_range(0, 3));
      mem_wr      = 1'($urandom_range(0, 1));
      mem_req     = ($urandom_range(0, 3) == 0);
      mem_ready   = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      model_cycle(e);
      chk($sformatf("rand%0d", n), outv, e);
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
